fft_frame_sequencer: RTL and testbench
======================================

// Module: fft_frame_sequencer
// PURPOSE
//  Frame-level controller for the iterative FFT core (top_fft_iter). Accepts complex samples on a valid/ready
//  stream, writes exactly 2^AWL of them into the core, waits for the transform, then drains results through an
//  output FIFO to a valid/ready stream with a LAST marker. Tracks frame count and sticky length/overflow errors.
// PARAMETERS
//  DWL      15  sample MSB index; samples are DWL+1 bits (real and imag each)
//  AWL      10  log2 of FFT length N; must match the core instance
//  FIFO_AW  4   log2 of output FIFO depth (16 entries)
//  CNT_W    16  width of FRAME_CNT
// PORTS
//  CLK         in   1        clock, rising edge
//  RST         in   1        synchronous reset, active high
//  EN          in   1        global enable; low freezes FSM, counters and FIFO pointers (core EN driven by it)
//  CLR_ERR     in   1        one-cycle pulse clears ERR_LEN and ERR_OVF
//  s_VALID     in   1        input sample valid
//  s_READY     out  1        sequencer can accept a sample
//  s_DATA_R/I  in   DWL+1    input sample, real/imag
//  s_LAST      in   1        producer's end-of-frame marker (checked, not trusted)
//  fft_DATA_R/I out DWL+1    to core i_DATA_R/I (registered)
//  fft_WR      out  1        to core i_WR_DATA; one sample per high cycle
//  fft_FULL    in   1        core FULL: loading closed / computing / unloading
//  fft_VALID   in   1        core VALID: one result sample per high cycle, no backpressure
//  fft_Q_R/I   in   DWL+1    core o_DATA_R/I
//  m_VALID     out  1        output sample valid (FIFO not empty)
//  m_READY     in   1        consumer accepts
//  m_DATA_R/I  out  DWL+1    result sample
//  m_LAST      out  1        high with the N-th result of a frame
//  BUSY        out  1        FSM not in IDLE
//  FRAME_CNT   out  CNT_W    completed frames, wraps at 2^CNT_W
//  ERR_LEN     out  1        sticky: s_LAST mismatched sample count
//  ERR_OVF     out  1        sticky: result arrived with FIFO full (sample dropped)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters, FIFO empty. RST overrides EN; RST mid-frame abandons the frame
//   (core shares RST, so no residual state).
//  Core contract: write accepted when fft_WR=1; fft_FULL rises after N-th write and stays high until the last
//   VALID; exactly N VALID cycles per frame.
//  FSM: IDLE -> LOAD on first accepted s sample (counted as sample 0).
//   LOAD: s_READY = EN & ~fft_FULL; each handshake registers sample to fft_DATA_*, fft_WR=1 next cycle,
//    in_cnt++. On handshake with in_cnt==N-1 -> CALC. s_LAST high when in_cnt!=N-1, or low when in_cnt==N-1,
//    sets ERR_LEN; frame boundary is always the count.
//   CALC: s_READY=0; first fft_VALID -> UNLOAD (that sample is captured).
//   UNLOAD: every fft_VALID pushes {R,I,last=(out_cnt==N-1)} to FIFO, out_cnt++; after N-th push -> IDLE,
//    FRAME_CNT++. Next frame may load while FIFO still drains.
//  Input latency: handshake -> fft_WR one cycle. Output: fft_VALID -> m_VALID earliest one cycle later.
//  FIFO: push on fft_VALID & EN; pop on m_VALID & m_READY. Push into full FIFO with simultaneous pop is
//   accepted; without pop the sample is dropped, ERR_OVF=1, out_cnt still advances (frame stays aligned).
//  fft_VALID outside CALC/UNLOAD ignored and sets ERR_OVF. CLR_ERR coincident with a new error: error wins.
//  FRAME_CNT wraps 2^CNT_W-1 -> 0. Counters are AWL bits; N-1 is all ones.
// STRUCTURE
//  Header fft_seq_defs.vh: FSM encodings (IDLE=2'd0, LOAD=1, CALC=2, UNLOAD=3).
//  Sub-module fft_out_fifo: sync FIFO, width 2*(DWL+1)+1, depth 2^FIFO_AW, full/empty, registered read.
//  Top: FSM, in/out counters, error logic, input register.
// TESTING (AWL=3, N=8, with real top_fft_iter)
//  1 Impulse: samples (1000,0),0x7 with s_LAST on 8th, m_READY=1 -> 8 results all 1000>>scale, m_LAST on 8th,
//    FRAME_CNT=1, no errors.
//  2 Back-to-back: 3 frames streamed continuously -> s_READY low exactly during CALC/UNLOAD, 24 results,
//    FRAME_CNT=3, m_LAST count=3.
//  3 Backpressure: m_READY=0 through full unload with FIFO_AW=2 -> 4 kept, ERR_OVF=1, out_cnt ends at 8,
//    m_LAST still delivered on next frame's 8th result.
//  4 Length: s_LAST on sample 5 -> ERR_LEN=1, frame still 8 samples; CLR_ERR pulse -> ERR_LEN=0.
//  5 Reset mid-CALC: RST one cycle -> all outputs 0, IDLE, next full frame correct.
//  6 EN low 5 cycles inside LOAD -> no fft_WR, s_READY=0, counters hold; frame completes correctly.

Source files
------------

// File: rtl/fft_frame_sequencer_pkg.sv
// rtl/fft_frame_sequencer_pkg.sv - FSM encoding and helpers shared by the FFT frame sequencer
package fft_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CALC   = 2'd2,
        ST_UNLOAD = 2'd3
    } seq_state_e;

    // IDLE and LOAD both take input samples; CALC and UNLOAD belong to the core.
    function automatic logic accepts_input(input seq_state_e st);
        return (st == ST_IDLE) || (st == ST_LOAD);
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// rtl/fft_frame_sequencer_if.sv - complex-sample valid/ready stream with end-of-frame marker
interface fft_frame_sequencer_if #(
    parameter int DW = 16
) ();
    logic          VALID;
    logic          READY;
    logic [DW-1:0] DATA_R;
    logic [DW-1:0] DATA_I;
    logic          LAST;

    modport master (output VALID, DATA_R, DATA_I, LAST, input READY);
    modport slave  (input VALID, DATA_R, DATA_I, LAST, output READY);
endinterface

// File: rtl/fft_frame_sequencer_fifo.sv
// rtl/fft_frame_sequencer_fifo.sv - synchronous result FIFO; read port is a mux over registered storage
module fft_out_fifo #(
    parameter int W  = 33,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = count_q[AW];
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - loads N samples into the iterative FFT core and drains results with LAST
module fft_frame_sequencer
    import fft_frame_sequencer_pkg::*;
#(
    parameter int DWL     = 15,
    parameter int AWL     = 10,
    parameter int FIFO_AW = 4,
    parameter int CNT_W   = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  CLR_ERR,
    fft_frame_sequencer_if.slave  s,
    output logic [DWL:0]          fft_DATA_R,
    output logic [DWL:0]          fft_DATA_I,
    output logic                  fft_WR,
    input  logic                  fft_FULL,
    input  logic                  fft_VALID,
    input  logic [DWL:0]          fft_Q_R,
    input  logic [DWL:0]          fft_Q_I,
    fft_frame_sequencer_if.master m,
    output logic                  BUSY,
    output logic [CNT_W-1:0]      FRAME_CNT,
    output logic                  ERR_LEN,
    output logic                  ERR_OVF
);
    localparam int DW = DWL + 1;
    localparam int FW = 2 * DW + 1;

    seq_state_e       state_q, state_d;
    logic [AWL-1:0]   in_cnt_q, in_cnt_d;
    logic [AWL-1:0]   out_cnt_q, out_cnt_d;
    logic [DWL:0]     data_r_q, data_r_d, data_i_q, data_i_d;
    logic             fft_wr_q, fft_wr_d;
    logic             busy_q, busy_d;
    logic             err_len_q, err_len_d;
    logic             err_ovf_q, err_ovf_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic             s_ready, in_hs, core_take, len_err, ovf_err;
    logic             fifo_full, fifo_empty, fifo_pop, m_valid;
    logic [FW-1:0]    fifo_rd;

    assign s_ready   = EN && !RST && !fft_FULL && accepts_input(state_q);
    assign in_hs     = s.VALID && s_ready;
    assign core_take = EN && fft_VALID && !accepts_input(state_q);
    assign m_valid   = EN && !fifo_empty;
    assign fifo_pop  = m_valid && m.READY;

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        data_r_d    = data_r_q;
        data_i_d    = data_i_q;
        frame_cnt_d = frame_cnt_q;
        fft_wr_d    = in_hs;
        len_err     = 1'b0;
        // Core results outside CALC/UNLOAD have nowhere to go and are flagged as lost.
        ovf_err     = EN && fft_VALID && accepts_input(state_q);

        if (in_hs) begin
            data_r_d = s.DATA_R;
            data_i_d = s.DATA_I;
            in_cnt_d = in_cnt_q + AWL'(1);
            state_d  = (&in_cnt_q) ? ST_CALC : ST_LOAD;
            len_err  = (s.LAST != (&in_cnt_q));
        end

        // Dropped results still advance out_cnt so LAST stays on the frame's N-th sample.
        if (core_take) begin
            out_cnt_d = out_cnt_q + AWL'(1);
            state_d   = (&out_cnt_q) ? ST_IDLE : ST_UNLOAD;
            if (&out_cnt_q) frame_cnt_d = frame_cnt_q + CNT_W'(1);
            if (fifo_full && !fifo_pop) ovf_err = 1'b1;
        end

        busy_d    = (state_d != ST_IDLE);
        err_len_d = (err_len_q && !CLR_ERR) || len_err;
        err_ovf_d = (err_ovf_q && !CLR_ERR) || ovf_err;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            data_r_q    <= '0;
            data_i_q    <= '0;
            fft_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_len_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            data_r_q    <= data_r_d;
            data_i_q    <= data_i_d;
            fft_wr_q    <= fft_wr_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            err_len_q   <= err_len_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    fft_out_fifo #(
        .W  (FW),
        .AW (FIFO_AW)
    ) u_out_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (core_take),
        .wr_data ({fft_Q_R, fft_Q_I, &out_cnt_q}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign s.READY    = s_ready;
    assign fft_DATA_R = data_r_q;
    assign fft_DATA_I = data_i_q;
    assign fft_WR     = fft_wr_q;
    assign m.VALID    = m_valid;
    assign m.DATA_R   = m_valid ? fifo_rd[FW-1 -: DW] : '0;
    assign m.DATA_I   = m_valid ? fifo_rd[DW:1] : '0;
    assign m.LAST     = m_valid && fifo_rd[0];
    assign BUSY       = busy_q;
    assign FRAME_CNT  = frame_cnt_q;
    assign ERR_LEN    = err_len_q;
    assign ERR_OVF    = err_ovf_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - directed bench for fft_frame_sequencer with an identity-transform core model
module tb_fft_frame_sequencer;
    logic clk = 1'b0;
    logic rst, en, clr_err, spur;
    logic [15:0] fft_r, fft_i, core_qr, core_qi;
    logic fft_wr, core_full, core_valid, busy, err_len, err_ovf;
    logic [15:0] frame_cnt;
    int total = 0;
    int bad = 0;
    int rdy_bad = 0;
    logic [15:0] rr[$];
    logic [15:0] ri[$];
    logic        rl[$];

    fft_frame_sequencer_if #(.DW(16)) s_if ();
    fft_frame_sequencer_if #(.DW(16)) m_if ();

    fft_frame_sequencer #(.DWL(15), .AWL(3), .FIFO_AW(2), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .EN(en), .CLR_ERR(clr_err), .s(s_if),
        .fft_DATA_R(fft_r), .fft_DATA_I(fft_i), .fft_WR(fft_wr),
        .fft_FULL(core_full), .fft_VALID(core_valid | spur),
        .fft_Q_R(core_qr), .fft_Q_I(core_qi), .m(m_if),
        .BUSY(busy), .FRAME_CNT(frame_cnt), .ERR_LEN(err_len), .ERR_OVF(err_ovf)
    );

    always #5 clk = ~clk;

    // Core model: takes 8 writes, raises FULL, waits, then returns the samples unchanged in order.
    logic [15:0] bufr [8];
    logic [15:0] bufi [8];
    logic [1:0]  phase;
    logic [2:0]  wcnt, ocnt;
    int          dly;
    always @(posedge clk) begin
        if (rst) begin
            phase <= 2'd0; wcnt <= 3'd0; ocnt <= 3'd0; dly <= 0;
            core_full <= 1'b0; core_valid <= 1'b0; core_qr <= '0; core_qi <= '0;
        end else begin
            case (phase)
                2'd0: if (fft_wr) begin
                    bufr[wcnt] <= fft_r;
                    bufi[wcnt] <= fft_i;
                    wcnt <= wcnt + 3'd1;
                    if (wcnt == 3'd7) begin core_full <= 1'b1; phase <= 2'd1; dly <= 3; end
                end
                2'd1: if (dly == 0) phase <= 2'd2; else dly <= dly - 1;
                2'd2: begin
                    core_valid <= 1'b1;
                    core_qr <= bufr[ocnt];
                    core_qi <= bufi[ocnt];
                    ocnt <= ocnt + 3'd1;
                    if (ocnt == 3'd7) phase <= 2'd3;
                end
                default: begin core_valid <= 1'b0; core_full <= 1'b0; phase <= 2'd0; end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_if.VALID === 1'b1 && m_if.READY === 1'b1) begin
            rr.push_back(m_if.DATA_R); ri.push_back(m_if.DATA_I); rl.push_back(m_if.LAST);
        end
        if (core_full === 1'b1 && s_if.READY !== 1'b0) rdy_bad++;
    end

    task automatic send_sample(input logic [15:0] r, input logic [15:0] i, input logic last);
        int t;
        t = 0;
        s_if.VALID = 1'b1; s_if.DATA_R = r; s_if.DATA_I = i; s_if.LAST = last;
        @(negedge clk);
        while (s_if.READY !== 1'b1 && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) begin total++; bad++; $display("FAIL send_timeout ready=%b required=1", s_if.READY); end
        @(posedge clk); #1;
        s_if.VALID = 1'b0; s_if.LAST = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int t;
        t = 0;
        while (rr.size() < n && t < 300) begin @(posedge clk); #1; t++; end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy === 1'b1 && t < 200) begin @(posedge clk); #1; t++; end
    endtask

    task automatic clear_results();
        rr.delete(); ri.delete(); rl.delete();
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1; @(posedge clk); #1; clr_err = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
        total++; if ({err_len, err_ovf} !== 2'b00) begin bad++; $display("FAIL reset_errs got=%b want=00", {err_len, err_ovf}); end
        total++; if ({fft_wr, s_if.READY, m_if.VALID, m_if.LAST} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes got=%b want=0000", {fft_wr, s_if.READY, m_if.VALID, m_if.LAST}); end
    endtask

    task automatic test_impulse();
        clear_results();
        for (int k = 0; k < 8; k++) send_sample((k == 0) ? 16'd1000 : 16'd0, 16'd0, k == 7);
        wait_results(8);
        total++; if (rr.size() != 8) begin bad++; $display("FAIL impulse_count got=%0d want=8", rr.size()); end
        for (int k = 0; k < 8 && k < rr.size(); k++) begin
            total++;
            if (rr[k] !== ((k == 0) ? 16'd1000 : 16'd0) || ri[k] !== 16'd0 || rl[k] !== (k == 7)) begin
                bad++; $display("FAIL impulse_sample k=%0d got=%0d/%0d/%b want=%0d/0/%b", k, rr[k], ri[k], rl[k], (k == 0) ? 1000 : 0, k == 7);
            end
        end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL impulse_frame_cnt got=%0d want=1", frame_cnt); end
        total++; if ({busy, err_len, err_ovf} !== 3'b000) begin bad++; $display("FAIL impulse_flags got=%b want=000", {busy, err_len, err_ovf}); end
    endtask

    task automatic test_back_to_back();
        int lasts;
        clear_results();
        rdy_bad = 0;
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 8; k++) send_sample(16'(2000 + 8*f + k), 16'(3000 + 8*f + k), k == 7);
        wait_results(24);
        total++; if (rr.size() != 24) begin bad++; $display("FAIL b2b_count got=%0d want=24", rr.size()); end
        lasts = 0;
        for (int k = 0; k < 24 && k < rr.size(); k++) begin
            if (rl[k] === 1'b1) lasts++;
            total++;
            if (rr[k] !== 16'(2000 + k) || ri[k] !== 16'(3000 + k) || rl[k] !== (k % 8 == 7)) begin
                bad++; $display("FAIL b2b_sample k=%0d got=%0d/%0d/%b want=%0d/%0d/%b", k, rr[k], ri[k], rl[k], 2000 + k, 3000 + k, k % 8 == 7);
            end
        end
        total++; if (lasts != 3) begin bad++; $display("FAIL b2b_last_count got=%0d want=3", lasts); end
        total++; if (frame_cnt !== 16'd4) begin bad++; $display("FAIL b2b_frame_cnt got=%0d want=4", frame_cnt); end
        total++; if (rdy_bad != 0) begin bad++; $display("FAIL b2b_ready_while_full got=%0d want=0", rdy_bad); end
    endtask

    task automatic test_backpressure();
        clear_results();
        m_if.READY = 1'b0;
        for (int k = 0; k < 8; k++) send_sample(16'(500 + k), 16'(600 + k), k == 7);
        wait_idle();
        total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL bp_err_ovf got=%b want=1", err_ovf); end
        total++; if (frame_cnt !== 16'd5) begin bad++; $display("FAIL bp_frame_cnt got=%0d want=5", frame_cnt); end
        total++; if (m_if.VALID !== 1'b1) begin bad++; $display("FAIL bp_m_valid got=%b want=1", m_if.VALID); end
        m_if.READY = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        total++; if (rr.size() != 4) begin bad++; $display("FAIL bp_kept got=%0d want=4", rr.size()); end
        for (int k = 0; k < 4 && k < rr.size(); k++) begin
            total++;
            if (rr[k] !== 16'(500 + k) || ri[k] !== 16'(600 + k) || rl[k] !== 1'b0) begin
                bad++; $display("FAIL bp_kept_sample k=%0d got=%0d/%0d/%b want=%0d/%0d/0", k, rr[k], ri[k], rl[k], 500 + k, 600 + k);
            end
        end
        pulse_clr();
        total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL bp_clear got=%b want=0", err_ovf); end
        clear_results();
        for (int k = 0; k < 8; k++) send_sample(16'(700 + k), 16'(800 + k), k == 7);
        wait_results(8);
        for (int k = 0; k < 8 && k < rr.size(); k++) begin
            total++;
            if (rr[k] !== 16'(700 + k) || rl[k] !== (k == 7)) begin
                bad++; $display("FAIL bp_next_frame k=%0d got=%0d/%b want=%0d/%b", k, rr[k], rl[k], 700 + k, k == 7);
            end
        end
        total++; if (frame_cnt !== 16'd6) begin bad++; $display("FAIL bp_next_frame_cnt got=%0d want=6", frame_cnt); end
    endtask

    task automatic test_spurious_valid();
        clear_results();
        spur = 1'b1; @(posedge clk); #1; spur = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL spur_err_ovf got=%b want=1", err_ovf); end
        total++; if (rr.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL spur_ignored got=%0d/%b want=0/0", rr.size(), busy); end
        spur = 1'b1; clr_err = 1'b1; @(posedge clk); #1; spur = 1'b0; clr_err = 1'b0;
        total++; if (err_ovf !== 1'b1) begin bad++; $display("FAIL spur_error_wins got=%b want=1", err_ovf); end
        pulse_clr();
        total++; if (err_ovf !== 1'b0) begin bad++; $display("FAIL spur_clear got=%b want=0", err_ovf); end
    endtask

    task automatic test_length();
        clear_results();
        for (int k = 0; k < 8; k++) send_sample(16'(900 + k), 16'(950 + k), k == 5);
        wait_results(8);
        total++; if (rr.size() != 8) begin bad++; $display("FAIL len_count got=%0d want=8", rr.size()); end
        for (int k = 0; k < 8 && k < rr.size(); k++) begin
            total++;
            if (rr[k] !== 16'(900 + k) || ri[k] !== 16'(950 + k) || rl[k] !== (k == 7)) begin
                bad++; $display("FAIL len_sample k=%0d got=%0d/%0d/%b want=%0d/%0d/%b", k, rr[k], ri[k], rl[k], 900 + k, 950 + k, k == 7);
            end
        end
        total++; if (err_len !== 1'b1) begin bad++; $display("FAIL len_err got=%b want=1", err_len); end
        total++; if (frame_cnt !== 16'd7) begin bad++; $display("FAIL len_frame_cnt got=%0d want=7", frame_cnt); end
        pulse_clr();
        total++; if (err_len !== 1'b0) begin bad++; $display("FAIL len_clear got=%b want=0", err_len); end
    endtask

    task automatic test_en_low();
        clear_results();
        send_sample(16'd1100, 16'd1200, 1'b0);
        total++; if (fft_wr !== 1'b1 || fft_r !== 16'd1100 || fft_i !== 16'd1200) begin
            bad++; $display("FAIL en_wr_latency got=%b/%0d/%0d want=1/1100/1200", fft_wr, fft_r, fft_i); end
        for (int k = 1; k < 3; k++) send_sample(16'(1100 + k), 16'(1200 + k), 1'b0);
        en = 1'b0;
        s_if.VALID = 1'b1; s_if.DATA_R = 16'd1103; s_if.DATA_I = 16'd1203; s_if.LAST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (s_if.READY !== 1'b0) begin bad++; $display("FAIL en_ready cyc=%0d got=%b want=0", i, s_if.READY); end
            if (i > 0) begin
                total++; if (fft_wr !== 1'b0) begin bad++; $display("FAIL en_wr cyc=%0d got=%b want=0", i, fft_wr); end
            end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL en_busy got=%b want=1", busy); end
        @(posedge clk); #1;
        en = 1'b1;
        for (int k = 3; k < 8; k++) send_sample(16'(1100 + k), 16'(1200 + k), k == 7);
        wait_results(8);
        total++; if (rr.size() != 8) begin bad++; $display("FAIL en_count got=%0d want=8", rr.size()); end
        for (int k = 0; k < 8 && k < rr.size(); k++) begin
            total++;
            if (rr[k] !== 16'(1100 + k) || ri[k] !== 16'(1200 + k) || rl[k] !== (k == 7)) begin
                bad++; $display("FAIL en_sample k=%0d got=%0d/%0d/%b want=%0d/%0d/%b", k, rr[k], ri[k], rl[k], 1100 + k, 1200 + k, k == 7);
            end
        end
        total++; if (frame_cnt !== 16'd8 || err_len !== 1'b0) begin
            bad++; $display("FAIL en_frame got=%0d/%b want=8/0", frame_cnt, err_len); end
    endtask

    task automatic test_reset_mid_calc();
        clear_results();
        for (int k = 0; k < 8; k++) send_sample(16'(1300 + k), 16'(1400 + k), k == 7);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_calc_busy got=%b want=1", busy); end
        rst = 1'b1; @(posedge clk); #1;
        total++; if ({busy, fft_wr, s_if.READY, m_if.VALID} !== 4'b0000) begin
            bad++; $display("FAIL rst_calc_strobes got=%b want=0000", {busy, fft_wr, s_if.READY, m_if.VALID}); end
        total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL rst_calc_frame_cnt got=%0d want=0", frame_cnt); end
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        total++; if (rr.size() != 0) begin bad++; $display("FAIL rst_calc_abandoned got=%0d want=0", rr.size()); end
        for (int k = 0; k < 8; k++) send_sample(16'(1500 + k), 16'(1600 + k), k == 7);
        wait_results(8);
        total++; if (rr.size() != 8) begin bad++; $display("FAIL rst_next_count got=%0d want=8", rr.size()); end
        for (int k = 0; k < 8 && k < rr.size(); k++) begin
            total++;
            if (rr[k] !== 16'(1500 + k) || ri[k] !== 16'(1600 + k) || rl[k] !== (k == 7)) begin
                bad++; $display("FAIL rst_next_sample k=%0d got=%0d/%0d/%b want=%0d/%0d/%b", k, rr[k], ri[k], rl[k], 1500 + k, 1600 + k, k == 7);
            end
        end
        total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL rst_next_frame_cnt got=%0d want=1", frame_cnt); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b1; clr_err = 1'b0; spur = 1'b0;
        s_if.VALID = 1'b0; s_if.DATA_R = '0; s_if.DATA_I = '0; s_if.LAST = 1'b0;
        m_if.READY = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_impulse();
        test_back_to_back();
        test_backpressure();
        test_spurious_valid();
        test_length();
        test_en_low();
        test_reset_mid_calc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
